// File: rtl/dat_ctrl.sv
// SD host DAT-path transfer sequencer: latches transfer geometry on start, gates the
// physical layer's read/write flags with FIFO status, and handles completion, stall and abort.
`ifndef BLOCK_SZ_WIDTH
`define BLOCK_SZ_WIDTH 12
`endif
`ifndef BLOCK_CNT_WIDTH
`define BLOCK_CNT_WIDTH 16
`endif

module dat_ctrl #(
  parameter int unsigned              TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_VAL   = 16'hFFFF
) (
  input  logic                        sd_clk,
  input  logic                        rst,
  input  logic                        start_write,
  input  logic                        start_read,
  input  logic                        abort,
  input  logic                        err_clr,
  input  logic [`BLOCK_SZ_WIDTH-1:0]  block_sz_in,
  input  logic [`BLOCK_CNT_WIDTH-1:0] block_cnt_in,
  input  logic                        multiple_in,
  input  logic                        tx_fifo_empty,
  input  logic                        rx_fifo_full,
  input  logic                        tx_buf_rd_enb,
  input  logic                        rx_buf_wr_enb,
  input  logic                        dat_phys_busy,
  input  logic                        tf_finished,
  output logic                        write_flag,
  output logic                        read_flag,
  output logic                        multiple,
  output logic [`BLOCK_SZ_WIDTH-1:0]  block_sz,
  output logic [`BLOCK_CNT_WIDTH-1:0] block_cnt,
  output logic                        dat_phys_rst_L,
  output logic                        busy,
  output logic                        xfer_done,
  output logic                        cmd_err,
  output logic                        timeout_err
);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    ARM    = 6'b000010,
    ACTIVE = 6'b000100,
    DONE   = 6'b001000,
    FLUSH  = 6'b010000,
    ERROR  = 6'b100000
  } state_t;

  state_t                   state, next_state;
  logic                     dir_wr_q;
  logic                     pend_q, pend_d;
  logic                     flush_cnt_q;
  logic [TIMEOUT_WIDTH-1:0] stall_q;
  logic                     latch_c;
  logic                     cmd_err_c;
  logic                     start_valid;

  assign start_valid = (start_write ^ start_read) && !(multiple_in && (block_cnt_in == '0));

  // State register
  always_ff @(posedge sd_clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and transfer control
  always_comb begin
    next_state = state;
    latch_c    = 1'b0;
    cmd_err_c  = 1'b0;
    pend_d     = pend_q;
    case (state)
      IDLE: begin
        if (start_valid) begin
          latch_c    = 1'b1;
          next_state = ARM;
        end else if (start_write || start_read) begin
          cmd_err_c = 1'b1;
        end
      end
      ARM: begin
        if (abort) begin
          next_state = FLUSH;
          pend_d     = 1'b0;
        end else if (!dat_phys_busy) begin
          next_state = ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort) begin
          next_state = FLUSH;
          pend_d     = 1'b0;
        end else if (tf_finished) begin
          next_state = DONE;
        end else if (stall_q == TIMEOUT_VAL) begin
          next_state = FLUSH;
          pend_d     = 1'b1;
        end
      end
      DONE: begin
        if (abort) begin
          next_state = FLUSH;
          pend_d     = 1'b0;
        end else begin
          next_state = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_q) next_state = pend_q ? ERROR : IDLE;
      end
      ERROR: begin
        if (err_clr) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latched geometry, stall and flush counters
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      dir_wr_q    <= 1'b0;
      multiple    <= 1'b0;
      block_sz    <= '0;
      block_cnt   <= '0;
      pend_q      <= 1'b0;
      flush_cnt_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (latch_c) begin
        dir_wr_q  <= start_write;
        multiple  <= multiple_in;
        block_sz  <= block_sz_in;
        block_cnt <= block_cnt_in;
      end
      pend_q      <= pend_d;
      flush_cnt_q <= (state == FLUSH) ? !flush_cnt_q : 1'b0;
      if (state == ARM) begin
        stall_q <= '0;
      end else if (state == ACTIVE) begin
        if (tx_buf_rd_enb || rx_buf_wr_enb) stall_q <= '0;
        else if (stall_q != '1)             stall_q <= stall_q + TIMEOUT_WIDTH'(1);
      end
    end
  end

  // Registered status outputs, decoded from the upcoming state
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      busy           <= 1'b0;
      xfer_done      <= 1'b0;
      cmd_err        <= 1'b0;
      timeout_err    <= 1'b0;
      dat_phys_rst_L <= 1'b0;
    end else begin
      busy           <= (next_state != IDLE);
      xfer_done      <= (next_state == DONE);
      cmd_err        <= cmd_err_c;
      timeout_err    <= (next_state == ERROR);
      dat_phys_rst_L <= (next_state != FLUSH);
    end
  end

  // Flags follow FIFO status directly so backpressure takes effect the same cycle
  assign write_flag = (state == ACTIVE) &&  dir_wr_q && !tx_fifo_empty;
  assign read_flag  = (state == ACTIVE) && !dir_wr_q && !rx_fifo_full;

endmodule

// File: tb/tb_dat_ctrl.sv
// Bench for dat_ctrl: directed scenarios then random stimulus, all checked each cycle
// against a behavioural model of the transfer sequencer.
`ifndef BLOCK_SZ_WIDTH
`define BLOCK_SZ_WIDTH 12
`endif
`ifndef BLOCK_CNT_WIDTH
`define BLOCK_CNT_WIDTH 16
`endif

module tb_dat_ctrl;
  localparam int unsigned TO  = 8;
  localparam int unsigned SAT = 65535;
  localparam int P_IDLE = 0, P_ARM = 1, P_ACT = 2, P_DONE = 3, P_FLUSH = 4, P_ERR = 5;

  logic sd_clk = 1'b0;
  logic rst, start_write, start_read, abort, err_clr, multiple_in;
  logic [`BLOCK_SZ_WIDTH-1:0]  block_sz_in;
  logic [`BLOCK_CNT_WIDTH-1:0] block_cnt_in;
  logic tx_fifo_empty, rx_fifo_full, tx_buf_rd_enb, rx_buf_wr_enb, dat_phys_busy, tf_finished;
  logic write_flag, read_flag, multiple, dat_phys_rst_L, busy, xfer_done, cmd_err, timeout_err;
  logic [`BLOCK_SZ_WIDTH-1:0]  block_sz;
  logic [`BLOCK_CNT_WIDTH-1:0] block_cnt;

  int total = 0;
  int bad   = 0;

  always #5 sd_clk = ~sd_clk;

  dat_ctrl #(.TIMEOUT_WIDTH(16), .TIMEOUT_VAL(16'd8)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_write(start_write), .start_read(start_read),
    .abort(abort), .err_clr(err_clr), .block_sz_in(block_sz_in), .block_cnt_in(block_cnt_in),
    .multiple_in(multiple_in), .tx_fifo_empty(tx_fifo_empty), .rx_fifo_full(rx_fifo_full),
    .tx_buf_rd_enb(tx_buf_rd_enb), .rx_buf_wr_enb(rx_buf_wr_enb), .dat_phys_busy(dat_phys_busy),
    .tf_finished(tf_finished), .write_flag(write_flag), .read_flag(read_flag),
    .multiple(multiple), .block_sz(block_sz), .block_cnt(block_cnt),
    .dat_phys_rst_L(dat_phys_rst_L), .busy(busy), .xfer_done(xfer_done),
    .cmd_err(cmd_err), .timeout_err(timeout_err)
  );

  // Behavioural model
  int  m_phase, m_stall, m_flush_n;
  bit  m_wr, m_mult, m_cmd_err, m_in_reset, m_pend;
  int  m_bsz, m_bcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("busy",        32'(busy),           32'(m_phase != P_IDLE));
    check("write_flag",  32'(write_flag),     32'(m_phase == P_ACT && m_wr && !tx_fifo_empty));
    check("read_flag",   32'(read_flag),      32'(m_phase == P_ACT && !m_wr && !rx_fifo_full));
    check("xfer_done",   32'(xfer_done),      32'(m_phase == P_DONE));
    check("cmd_err",     32'(cmd_err),        32'(m_cmd_err));
    check("timeout_err", 32'(timeout_err),    32'(m_phase == P_ERR));
    check("phys_rst_L",  32'(dat_phys_rst_L), 32'(!(m_in_reset || m_phase == P_FLUSH)));
    check("multiple",    32'(multiple),       32'(m_mult));
    check("block_sz",    32'(block_sz),       32'(m_bsz));
    check("block_cnt",   32'(block_cnt),      32'(m_bcnt));
  endtask

  task automatic go_flush(input bit pend);
    m_phase   = P_FLUSH;
    m_flush_n = 0;
    m_pend    = pend;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    bit one_start, ok;
    if (rst) begin
      m_phase = P_IDLE; m_wr = 0; m_mult = 0; m_bsz = 0; m_bcnt = 0;
      m_cmd_err = 0; m_in_reset = 1; m_pend = 0; m_stall = 0; m_flush_n = 0;
      return;
    end
    m_in_reset = 0;
    m_cmd_err  = 0;
    case (m_phase)
      P_IDLE: begin
        one_start = (start_write + start_read) == 1;
        ok = one_start && !(multiple_in && block_cnt_in == 0);
        if (ok) begin
          m_wr = start_write; m_mult = multiple_in;
          m_bsz = int'(block_sz_in); m_bcnt = int'(block_cnt_in);
          m_phase = P_ARM;
        end else if (start_write || start_read) m_cmd_err = 1;
      end
      P_ARM: begin
        if (abort) go_flush(0);
        else if (!dat_phys_busy) begin m_phase = P_ACT; m_stall = 0; end
      end
      P_ACT: begin
        if (abort) go_flush(0);
        else if (tf_finished) m_phase = P_DONE;
        else if (m_stall == TO) go_flush(1);
        if (tx_buf_rd_enb || rx_buf_wr_enb) m_stall = 0;
        else if (m_stall < SAT) m_stall++;
      end
      P_DONE: if (abort) go_flush(0); else m_phase = P_IDLE;
      P_FLUSH: begin
        m_flush_n++;
        if (m_flush_n == 2) m_phase = m_pend ? P_ERR : P_IDLE;
      end
      P_ERR: if (err_clr) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic tick();
    @(negedge sd_clk);
    check_all();
    model_step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; start_write = 0; start_read = 0; abort = 0; err_clr = 0;
    block_sz_in = '0; block_cnt_in = '0; multiple_in = 0;
    tx_fifo_empty = 0; rx_fifo_full = 0; tx_buf_rd_enb = 0; rx_buf_wr_enb = 0;
    dat_phys_busy = 0; tf_finished = 0;
  endtask

  task automatic rand_inputs();
    rst           = $urandom_range(0, 299) == 0;
    start_write   = $urandom_range(0, 3) == 0;
    start_read    = $urandom_range(0, 3) == 0;
    abort         = $urandom_range(0, 39) == 0;
    err_clr       = $urandom_range(0, 5) == 0;
    block_sz_in   = `BLOCK_SZ_WIDTH'($urandom);
    block_cnt_in  = `BLOCK_CNT_WIDTH'($urandom_range(0, 3));
    multiple_in   = $urandom_range(0, 1) == 1;
    tx_fifo_empty = $urandom_range(0, 2) == 0;
    rx_fifo_full  = $urandom_range(0, 2) == 0;
    tx_buf_rd_enb = $urandom_range(0, 11) == 0;
    rx_buf_wr_enb = $urandom_range(0, 11) == 0;
    dat_phys_busy = $urandom_range(0, 2) == 0;
    tf_finished   = $urandom_range(0, 15) == 0;
  endtask

  initial begin
    quiet();
    rst = 1;
    model_step();
    @(posedge sd_clk);
    #1;
    tick();
    rst = 0;
    tick();
    // Single write
    start_write = 1; block_sz_in = 12'd512; tick();
    start_write = 0; repeat (4) tick();
    tf_finished = 1; tick();
    tf_finished = 0; repeat (2) tick();
    // Multi-block read with backpressure
    start_read = 1; multiple_in = 1; block_cnt_in = 16'd3; tick();
    start_read = 0; multiple_in = 0; block_cnt_in = 0;
    for (int i = 0; i < 8; i++) begin
      rx_fifo_full = i[0]; rx_buf_wr_enb = 1; tick();
    end
    rx_fifo_full = 0; rx_buf_wr_enb = 0; tf_finished = 1; tick();
    tf_finished = 0; repeat (2) tick();
    // Command errors
    start_write = 1; start_read = 1; tick();
    start_write = 0; start_read = 0; tick();
    start_read = 1; multiple_in = 1; block_cnt_in = 0; tick();
    start_read = 0; multiple_in = 0; repeat (2) tick();
    // Stall timeout then clear
    start_write = 1; tick();
    start_write = 0; repeat (16) tick();
    err_clr = 1; tick();
    err_clr = 0; repeat (2) tick();
    // Abort coincident with tf_finished
    start_read = 1; tick();
    start_read = 0; repeat (3) tick();
    abort = 1; tf_finished = 1; tick();
    abort = 0; tf_finished = 0; repeat (5) tick();
    // ARM held by dat_phys_busy, then reset mid-transfer
    dat_phys_busy = 1; start_write = 1; tick();
    start_write = 0; repeat (5) tick();
    dat_phys_busy = 0; repeat (3) tick();
    rst = 1; tick();
    rst = 0; repeat (2) tick();
    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dat_ctrl.md
# dat_ctrl

Transfer sequencer for the SD host DAT path. It sits between the register/CMD layer and the DAT physical layer. It accepts one-cycle read/write start requests and latches the transfer geometry. It then gates the physical layer's `write_flag`/`read_flag` with FIFO status, detects completion or stall, and owns the physical layer's reset so that aborts and timeouts leave the DAT engine in IDLE.

## Interface
Parameters:
- TIMEOUT_WIDTH, 16: width of the stall counter.
- TIMEOUT_VAL, 16'hFFFF: consecutive no-progress cycles in ACTIVE that raise a timeout.

Ports:
- sd_clk  in  1  SD clock; every register is on its posedge.
- rst  in  1  synchronous reset, active-high.
- start_write / start_read  in  1 / 1  single-cycle transfer requests; sampled only in IDLE.
- abort  in  1  cancels any transfer in progress.
- err_clr  in  1  clears `timeout_err`.
- block_sz_in  in  `BLOCK_SZ_WIDTH  block size; latched on start.
- block_cnt_in  in  `BLOCK_CNT_WIDTH  block count; latched on start.
- multiple_in  in  1  multi-block mode; latched on start.
- tx_fifo_empty / rx_fifo_full  in  1 / 1  FIFO status.
- tx_buf_rd_enb / rx_buf_wr_enb  in  1 / 1  progress strobes from the DAT physical layer.
- dat_phys_busy / tf_finished  in  1 / 1  status from the DAT physical layer.
- write_flag / read_flag  out  1 / 1  to the DAT physical layer.
- multiple  out  1  to the DAT physical layer.
- block_sz  out  `BLOCK_SZ_WIDTH  to the DAT physical layer.
- block_cnt  out  `BLOCK_CNT_WIDTH  to the DAT physical layer.
- dat_phys_rst_L  out  1  active-low reset for the DAT physical layer.
- busy  out  1  high whenever the state is not IDLE.
- xfer_done  out  1  one-cycle pulse on successful completion.
- cmd_err  out  1  one-cycle pulse when a start request is rejected.
- timeout_err  out  1  sticky stall error.

## Operation
- States: IDLE, ARM, ACTIVE, DONE, FLUSH, ERROR (one-hot).
- **IDLE**
  - A valid start requires exactly one of `start_write`/`start_read`, plus `block_cnt_in != 0` when `multiple_in` = 1.
  - On a valid start: latch direction, `block_sz`, `block_cnt` and `multiple`, then go to ARM.
  - Both starts high, or `multiple_in` = 1 with `block_cnt_in` = 0: `cmd_err` pulses, nothing is latched, state stays IDLE.
- **ARM**
  - Flags are held at 0.
  - Stay in ARM while `dat_phys_busy` = 1.
  - Otherwise clear the stall counter and go to ACTIVE.
  - ARM always lasts at least 1 cycle, so `multiple` is stable for at least one cycle before any flag rises.
- **ACTIVE**
  - Write: `write_flag` = !`tx_fifo_empty`.
  - Read: `read_flag` = !`rx_fifo_full`.
  - The inactive-direction flag is always 0. Flags are combinational from the state, the latched direction and FIFO status.
  - Stall counter: cleared on `tx_buf_rd_enb` | `rx_buf_wr_enb`, otherwise incremented. It saturates and never wraps.
  - Exit priority (highest first):
    1. `tf_finished` → DONE.
    2. Counter == TIMEOUT_VAL → FLUSH with a pending timeout.
- **DONE**
  - One cycle: `xfer_done` = 1, flags = 0, then go to IDLE.
- **FLUSH**
  - `dat_phys_rst_L` = 0 for exactly 2 cycles, flags = 0.
  - Then go to ERROR if a timeout is pending, else to IDLE.
- **ERROR**
  - `timeout_err` is set on entry and held.
  - `err_clr` clears it and the state goes to IDLE. Start requests are ignored in ERROR.
- **abort**: in ARM, ACTIVE or DONE, go to FLUSH on the next edge. `abort` has priority over `tf_finished` and timeout, and does not set `timeout_err`. It is ignored in IDLE, FLUSH and ERROR.
- Latched `block_sz`/`block_cnt`/`multiple` hold until the next valid start.

## Timing
- **Reset values** (while `rst` = 1, registered):
  - State = IDLE.
  - All outputs = 0, including `dat_phys_rst_L` (the physical layer is held in reset).
  - `dat_phys_rst_L` = 1 on the first cycle after `rst` deasserts.
- **Start path:** start at edge N → ARM during cycle N+1 (`busy` = 1) → ACTIVE at N+2 at the earliest → first flag in cycle N+2.
- **Completion:** `tf_finished` in cycle M → DONE in M+1 (`xfer_done` = 1, flags = 0) → IDLE in M+2 (`busy` = 0). A new start is accepted in M+2.
- **Timeout:** the counter reaches TIMEOUT_VAL in cycle T → FLUSH in T+1 and T+2 → ERROR in T+3.
- **Abort:** `abort` in cycle A → FLUSH in A+1 and A+2 → IDLE in A+3.
- **Simultaneous events:**
  - `err_clr` and `rst` together: `rst` wins.
  - A start in a non-IDLE state is dropped silently; `cmd_err` is not raised.
  - Mid-transfer `rst`: the next cycle is IDLE with all outputs at reset values.

## Test plan
- **Single write:** `start_write`, `block_sz`=512, `multiple`=0, `tx_fifo_empty`=0.
  → `write_flag`=1 two cycles after start; `tf_finished` → `xfer_done` 1 cycle later; `busy`=0 the cycle after that.
- **Multi-block read with backpressure:** `start_read`, `block_cnt`=3, `multiple`=1; toggle `rx_fifo_full`.
  → `read_flag` tracks !`rx_fifo_full` cycle-exact; `multiple`=1 and `block_cnt`=3 held throughout.
- **Command errors:**
  - `start_write` and `start_read` in the same cycle → `cmd_err` pulse, `busy` stays 0.
  - `multiple`=1 with `block_cnt`=0 → `cmd_err` pulse, `busy` stays 0.
- **Stall timeout:** TIMEOUT_VAL=8, no progress strobes.
  → FLUSH drives `dat_phys_rst_L`=0 for 2 cycles; then `timeout_err`=1 held; `err_clr` → IDLE.
- **Abort and ARM wait:**
  - `abort` while ACTIVE and simultaneous with `tf_finished` → no `xfer_done`, FLUSH 2 cycles, IDLE, `timeout_err`=0.
  - Start with `dat_phys_busy`=1 for 5 cycles → ARM holds 5 cycles, then ACTIVE.
- **Reset mid-transfer:** `rst` during ACTIVE → next cycle all outputs 0, `dat_phys_rst_L`=0; `dat_phys_rst_L`=1 after release.
